// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: tag widths and the ROB entry layout.
package ooo_pkg;

   localparam int PREG_WIDTH = 7;
   localparam int ROB_WIDTH  = 4;
   localparam int DEPTH      = 2 ** ROB_WIDTH;

   // One reorder-buffer slot: bookkeeping bits plus the rename mappings.
   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  has_dest;
      logic                  is_branch;
      logic [PREG_WIDTH-1:0] prd;
      logic [PREG_WIDTH-1:0] old_prd;
   } rob_entry_t;

endpackage : ooo_pkg

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail on dispatch, marks entries done
// on writeback, retires the head once done and squashes everything younger than
// a mispredicted branch.
module reorder_buffer #(
   parameter int PREG_WIDTH = ooo_pkg::PREG_WIDTH,
   parameter int ROB_WIDTH  = ooo_pkg::ROB_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dispatch_valid,
   input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
   input  logic [PREG_WIDTH-1:0] dispatch_prd,
   input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
   input  logic                  dispatch_has_dest,
   input  logic                  dispatch_is_branch,
   input  logic                  wb_valid,
   input  logic [ROB_WIDTH-1:0]  wb_rob_tag,
   input  logic                  wb_mispredict,
   output logic                  rob_full,
   output logic                  rob_empty,
   output logic                  commit_en,
   output logic [PREG_WIDTH-1:0] commit_old_preg,
   output logic                  retire_valid,
   output logic [ROB_WIDTH-1:0]  retire_rob_tag,
   output logic                  branch_mispredict,
   output logic                  rob_tag_err
);

   import ooo_pkg::*;

   localparam int DEPTH = 2 ** ROB_WIDTH;
   localparam int CNT_W = ROB_WIDTH + 1;

   rob_entry_t           entries   [DEPTH];
   rob_entry_t           entries_n [DEPTH];
   logic [ROB_WIDTH-1:0] head, head_n;
   logic [ROB_WIDTH-1:0] tail, tail_n;
   logic [CNT_W-1:0]     count, count_n;
   logic                 tag_err_n;

   rob_entry_t           head_entry;
   logic                 wb_hit;
   logic                 flush;
   logic                 do_retire;
   logic                 accept;
   logic [ROB_WIDTH-1:0] flush_span;
   logic [ROB_WIDTH-1:0] slot_off;

   // Occupancy flags straight from the entry count.
   assign rob_full  = (count == CNT_W'(DEPTH));
   assign rob_empty = (count == '0);

   // Event decode: every decision looks at pre-edge state only.
   assign head_entry = entries[head];
   assign do_retire  = head_entry.valid && head_entry.done;
   assign wb_hit     = wb_valid && entries[wb_rob_tag].valid;
   assign flush      = wb_hit && wb_mispredict && entries[wb_rob_tag].is_branch;
   // A dispatch that arrives with a flush is younger than the branch: drop it.
   assign accept     = dispatch_valid && !rob_full && !flush;
   assign flush_span = wb_rob_tag - head;

   // Next-state for the entry array, pointers, count and sticky tag error.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      entries_n = entries;
      head_n    = head;
      tail_n    = tail;
      count_n   = count;
      tag_err_n = rob_tag_err;
      slot_off  = '0;

      if (wb_hit) begin
         entries_n[wb_rob_tag].done = 1'b1;
      end

      // Squash entries younger than the branch, measured as distance from head.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_off = ROB_WIDTH'(i) - head;
            if (slot_off > flush_span) begin
               entries_n[i].valid = 1'b0;
               entries_n[i].done  = 1'b0;
            end
         end
         tail_n = wb_rob_tag + 1'b1;
      end

      if (accept) begin
         entries_n[tail] = '{valid:     1'b1,
                             done:      1'b0,
                             has_dest:  dispatch_has_dest,
                             is_branch: dispatch_is_branch,
                             prd:       dispatch_prd,
                             old_prd:   dispatch_old_prd};
         tail_n = tail + 1'b1;
         if (dispatch_rob_tag != tail) begin
            tag_err_n = 1'b1;
         end
      end

      if (do_retire) begin
         entries_n[head].valid = 1'b0;
         entries_n[head].done  = 1'b0;
         head_n = head + 1'b1;
      end

      // After a flush the buffer holds head..T; a full wrap yields DEPTH.
      if (flush) begin
         count_n = {1'b0, flush_span} + CNT_W'(1) - CNT_W'(do_retire);
      end else begin
         count_n = count + CNT_W'(accept) - CNT_W'(do_retire);
      end
   end

   // Entry array, pointers and count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the whole array is cleared, not just valid/done, so the entry
         // struct stays a single reset-domain register with no X payload.
         entries     <= '{default: '0};
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         rob_tag_err <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples the pre-edge values computed above.
         entries     <= entries_n;
         head        <= head_n;
         tail        <= tail_n;
         count       <= count_n;
         rob_tag_err <= tag_err_n;
      end
   end

   // Registered retire, commit and flush outputs, valid the cycle after the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retire_valid      <= 1'b0;
         retire_rob_tag    <= '0;
         commit_en         <= 1'b0;
         commit_old_preg   <= '0;
         branch_mispredict <= 1'b0;
      end else begin
         retire_valid      <= do_retire;
         retire_rob_tag    <= do_retire ? head : '0;
         commit_en         <= do_retire && head_entry.has_dest;
         commit_old_preg   <= (do_retire && head_entry.has_dest) ? head_entry.old_prd : '0;
         branch_mispredict <= flush;
      end
   end

endmodule : reorder_buffer

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with an in-order queue reference model.
module tb_reorder_buffer;

   localparam int PW    = 7;
   localparam int RW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          dispatch_valid;
   logic [RW-1:0] dispatch_rob_tag;
   logic [PW-1:0] dispatch_prd;
   logic [PW-1:0] dispatch_old_prd;
   logic          dispatch_has_dest;
   logic          dispatch_is_branch;
   logic          wb_valid;
   logic [RW-1:0] wb_rob_tag;
   logic          wb_mispredict;
   logic          rob_full;
   logic          rob_empty;
   logic          commit_en;
   logic [PW-1:0] commit_old_preg;
   logic          retire_valid;
   logic [RW-1:0] retire_rob_tag;
   logic          branch_mispredict;
   logic          rob_tag_err;

   always #5 clk = ~clk;

   reorder_buffer #(.PREG_WIDTH(PW), .ROB_WIDTH(RW)) dut (
      .clk                (clk),
      .reset              (reset),
      .dispatch_valid     (dispatch_valid),
      .dispatch_rob_tag   (dispatch_rob_tag),
      .dispatch_prd       (dispatch_prd),
      .dispatch_old_prd   (dispatch_old_prd),
      .dispatch_has_dest  (dispatch_has_dest),
      .dispatch_is_branch (dispatch_is_branch),
      .wb_valid           (wb_valid),
      .wb_rob_tag         (wb_rob_tag),
      .wb_mispredict      (wb_mispredict),
      .rob_full           (rob_full),
      .rob_empty          (rob_empty),
      .commit_en          (commit_en),
      .commit_old_preg    (commit_old_preg),
      .retire_valid       (retire_valid),
      .retire_rob_tag     (retire_rob_tag),
      .branch_mispredict  (branch_mispredict),
      .rob_tag_err        (rob_tag_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: program-order queue of live entries, oldest first.
   typedef struct {
      logic [RW-1:0] tag;
      logic [PW-1:0] old_prd;
      bit            has_dest;
      bit            is_branch;
      bit            done;
   } m_ent_t;

   m_ent_t        m_q[$];
   int            m_tail = 0;
   bit            e_rv   = 1'b0;
   logic [RW-1:0] e_rtag = '0;
   bit            e_ce   = 1'b0;
   logic [PW-1:0] e_old  = '0;
   bit            e_bm   = 1'b0;
   bit            e_err  = 1'b0;

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      m_ent_t r;
      m_ent_t tmp;
      bit     ret;
      bit     fl;
      int     k;
      int     pre;
      if (!reset) begin
         m_q.delete();
         m_tail = 0;
         e_rv = 0; e_rtag = '0; e_ce = 0; e_old = '0; e_bm = 0; e_err = 0;
         return;
      end
      pre = m_q.size();
      ret = (pre > 0) && m_q[0].done;
      r   = '{tag: '0, old_prd: '0, has_dest: 0, is_branch: 0, done: 0};
      if (ret) r = m_q[0];
      fl = 0;
      k  = -1;
      if (wb_valid) begin
         for (int j = 0; j < m_q.size(); j++)
            if (m_q[j].tag == wb_rob_tag) k = j;
      end
      if (k >= 0) begin
         tmp = m_q[k];
         tmp.done = 1;
         m_q[k] = tmp;
         if (wb_mispredict && tmp.is_branch) begin
            fl = 1;
            while (m_q.size() > k + 1) m_q.delete(m_q.size() - 1);
            m_tail = (int'(wb_rob_tag) + 1) % DEPTH;
         end
      end
      if (dispatch_valid && pre < DEPTH && !fl) begin
         if (dispatch_rob_tag != RW'(m_tail)) e_err = 1;
         m_q.push_back('{tag: RW'(m_tail), old_prd: dispatch_old_prd,
                         has_dest: dispatch_has_dest, is_branch: dispatch_is_branch,
                         done: 0});
         m_tail = (m_tail + 1) % DEPTH;
      end
      if (ret) m_q.delete(0);
      e_rv   = ret;
      e_rtag = ret ? r.tag : '0;
      e_ce   = ret && r.has_dest;
      e_old  = e_ce ? r.old_prd : '0;
      e_bm   = fl;
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (started) begin
         check("rob_full",          rob_full,          m_q.size() == DEPTH);
         check("rob_empty",         rob_empty,         m_q.size() == 0);
         check("retire_valid",      retire_valid,      e_rv);
         check("retire_rob_tag",    retire_rob_tag,    e_rtag);
         check("commit_en",         commit_en,         e_ce);
         check("commit_old_preg",   commit_old_preg,   e_old);
         check("branch_mispredict", branch_mispredict, e_bm);
         check("rob_tag_err",       rob_tag_err,       e_err);
      end
   end

   // Drive one cycle of inputs, step the model, return just after the next negedge.
   task automatic drive(input bit dv, input logic [RW-1:0] dtag, input logic [PW-1:0] dold,
                        input bit dhd, input bit dbr, input bit wv,
                        input logic [RW-1:0] wtag, input bit wmis);
      dispatch_valid     = dv;
      dispatch_rob_tag   = dtag;
      dispatch_old_prd   = dold;
      dispatch_prd       = dold ^ 7'h55;
      dispatch_has_dest  = dhd;
      dispatch_is_branch = dbr;
      wb_valid           = wv;
      wb_rob_tag         = wtag;
      wb_mispredict      = wmis;
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, '0, '0, 0, 0, 0, '0, 0);
   endtask

   task automatic disp(input logic [RW-1:0] tag, input logic [PW-1:0] old, input bit hd, input bit br);
      drive(1, tag, old, hd, br, 0, '0, 0);
   endtask

   task automatic wb(input logic [RW-1:0] tag, input bit mis);
      drive(0, '0, '0, 0, 0, 1, tag, mis);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      idle();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int issued;
      int committed;
      int budget;
      int cand[$];
      bit dv;
      bit wv;
      logic [RW-1:0] wtag;

      reset = 1'b0;
      dispatch_valid = 0; dispatch_rob_tag = '0; dispatch_prd = '0; dispatch_old_prd = '0;
      dispatch_has_dest = 0; dispatch_is_branch = 0;
      wb_valid = 0; wb_rob_tag = '0; wb_mispredict = 0;
      #1;
      started = 1'b1;
      idle();
      idle();
      reset = 1'b1;
      check("reset_empty", rob_empty, 1);
      check("reset_full",  rob_full,  0);
      check("reset_retire", retire_valid, 0);

      // In-order commit from out-of-order writeback.
      disp(0, 33, 1, 0);
      disp(1, 34, 1, 0);
      disp(2, 35, 1, 0);
      wb(2, 0);
      wb(0, 0);
      wb(1, 0);
      check("order_c0_en", commit_en, 1);
      check("order_c0",    commit_old_preg, 33);
      idle();
      check("order_c1",    commit_old_preg, 34);
      idle();
      check("order_c2",    commit_old_preg, 35);
      idle();
      check("order_done_en", commit_en, 0);
      check("order_empty",   rob_empty, 1);

      // Retire without a destination register.
      disp(3, 50, 0, 0);
      wb(3, 0);
      idle();
      check("nodest_rv",  retire_valid, 1);
      check("nodest_tag", retire_rob_tag, 3);
      check("nodest_ce",  commit_en, 0);
      check("nodest_old", commit_old_preg, 0);

      // Fill, overflow attempt, then free one slot.
      do_reset();
      for (int t = 0; t < DEPTH; t++) disp(RW'(t), PW'(t + 10), 1, 0);
      check("fill_full", rob_full, 1);
      disp(0, 99, 1, 0);
      check("overflow_full", rob_full, 1);
      wb(0, 0);
      check("full_wb_full", rob_full, 1);
      idle();
      check("full_ret_rv",  retire_valid, 1);
      check("full_ret_tag", retire_rob_tag, 0);
      check("full_ret_full", rob_full, 0);
      disp(0, 77, 1, 0);
      check("tail_wrap_err", rob_tag_err, 0);
      check("refill_full",   rob_full, 1);

      // Branch mispredict squash and recovery.
      do_reset();
      for (int t = 0; t < 6; t++) disp(RW'(t), PW'(20 + t), 1, t == 2);
      wb(2, 1);
      check("flush_pulse", branch_mispredict, 1);
      wb(4, 0);
      check("flush_pulse_end", branch_mispredict, 0);
      for (int t = 3; t < DEPTH; t++) disp(RW'(t), PW'(40 + t), 1, 0);
      check("flush_count_full", rob_full, 1);
      check("flush_tag_err",    rob_tag_err, 0);
      wb(0, 0);
      wb(1, 0);
      idle();
      idle();
      check("flush_br_tag", retire_rob_tag, 2);
      check("flush_br_old", commit_old_preg, 22);
      idle();
      check("flush_stop", retire_valid, 0);

      // Long run with random writeback order, wrapping the pointers twice.
      do_reset();
      issued = 0;
      committed = 0;
      budget = 0;
      while (committed < 40 && budget < 2000) begin
         dv = (issued < 40) && (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
         cand.delete();
         for (int j = 0; j < m_q.size(); j++) if (!m_q[j].done) cand.push_back(j);
         wv = 0;
         wtag = '0;
         if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
            wv = 1;
            wtag = m_q[cand[$urandom_range(0, cand.size() - 1)]].tag;
         end
         drive(dv, RW'(m_tail), PW'(issued + 1), 1, 0, wv, wtag, 0);
         if (dv) issued++;
         if (commit_en) begin
            check("wrap_order", commit_old_preg, PW'(committed + 1));
            committed++;
         end
         budget++;
      end
      check("wrap_commits", committed, 40);
      check("wrap_tag_err", rob_tag_err, 0);

      // Sticky tag error, then reset in the middle of traffic.
      do_reset();
      disp(0, 60, 1, 0);
      disp(1, 61, 1, 0);
      disp(2, 62, 1, 0);
      wb(0, 0);
      disp(5, 70, 1, 0);
      check("tag_err_set", rob_tag_err, 1);
      idle();
      idle();
      check("tag_err_sticky", rob_tag_err, 1);
      wb(1, 0);
      reset = 1'b0;
      #1;
      check("mid_rst_rv",   retire_valid, 0);
      check("mid_rst_ce",   commit_en, 0);
      check("mid_rst_old",  commit_old_preg, 0);
      check("mid_rst_tag",  retire_rob_tag, 0);
      check("mid_rst_bm",   branch_mispredict, 0);
      check("mid_rst_err",  rob_tag_err, 0);
      check("mid_rst_empty", rob_empty, 1);
      check("mid_rst_full", rob_full, 0);
      idle();
      reset = 1'b1;
      idle();
      idle();
      check("post_rst_ce",    commit_en, 0);
      check("post_rst_empty", rob_empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reorder_buffer

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter PREG_WIDTH, default 7, physical register tag width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB index width; DEPTH = 2**ROB_WIDTH (16).
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- dispatch_valid  in  1  allocate one entry this cycle
- dispatch_rob_tag  in  ROB_WIDTH  tag assigned by rename
- dispatch_prd  in  PREG_WIDTH  new physical destination
- dispatch_old_prd  in  PREG_WIDTH  previous mapping of rd
- dispatch_has_dest  in  1  instruction writes a non-x0 rd
- dispatch_is_branch  in  1  entry is a branch
- wb_valid  in  1  execution result complete
- wb_rob_tag  in  ROB_WIDTH  completing entry
- wb_mispredict  in  1  completing branch mispredicted
- rob_full  out  1  no free entry
- rob_empty  out  1  no valid entry
- commit_en  out  1  free commit_old_preg
- commit_old_preg  out  PREG_WIDTH  register returned to free list
- retire_valid  out  1  one entry retired (with or without dest)
- retire_rob_tag  out  ROB_WIDTH  retired entry tag
- branch_mispredict  out  1  one-cycle flush pulse to rename
- rob_tag_err  out  1  sticky: dispatch tag differed from tail

Function
REQ-004 SHALL keep head and tail pointers (ROB_WIDTH bits, natural wrap DEPTH-1 -> 0) and a ROB_WIDTH+1-bit count.
REQ-005 SHALL drive rob_full = (count == DEPTH) and rob_empty = (count == 0) combinationally.
REQ-006 SHALL, on dispatch_valid with !rob_full, write {valid=1, done=0, prd, old_prd, has_dest, is_branch} at tail; tail+1; count+1 at the same edge.
REQ-007 SHALL ignore dispatch_valid while rob_full; no state changes.
REQ-008 SHALL set rob_tag_err when an accepted dispatch has dispatch_rob_tag != tail; it clears only on reset.
REQ-009 SHALL, on wb_valid to a valid entry, set done; wb_valid to an invalid entry SHALL be ignored.
REQ-010 SHALL retire at most one entry per cycle: when the head entry is valid and done, clear it, head+1, count-1.
REQ-011 SHALL register retire outputs: retire_valid=1 and retire_rob_tag=head in the cycle after the retiring edge.
REQ-012 SHALL, in that cycle, assert commit_en with commit_old_preg=old_prd only when has_dest=1; otherwise commit_en=0.
REQ-013 SHALL, on wb_valid && wb_mispredict for valid branch tag T, mark T done, invalidate all entries younger than T, set tail=T+1, recompute count=(T-head)+1 (mod DEPTH; DEPTH when T+1==head).
REQ-014 SHALL pulse branch_mispredict for exactly the cycle after the REQ-013 edge.
REQ-015 SHALL drop a dispatch in the same cycle as a mispredict writeback (it is younger than T).
REQ-016 SHALL let a retire of the head proceed in the same cycle as a mispredict writeback; count reflects both.
REQ-017 SHALL accept dispatch and retire in one cycle while full: retire frees head, dispatch still rejected that cycle because rob_full is evaluated before the edge.
REQ-018 SHALL not free physical registers of squashed entries; rename reclaims them via its checkpoint.
REQ-019 SHALL drive commit_old_preg to 0 whenever commit_en=0.

Reset
REQ-020 SHALL, on reset low, asynchronously clear head, tail, count, all valid/done bits, rob_tag_err, commit_en, retire_valid, branch_mispredict, commit_old_preg, retire_rob_tag.
REQ-021 SHALL, after reset, show rob_empty=1, rob_full=0; reset mid-operation discards all entries without issuing commits.

Structure
REQ-022 SHALL take PREG_WIDTH, ROB_WIDTH, DEPTH and rob_entry_t {valid, done, has_dest, is_branch, prd, old_prd} from shared package ooo_pkg.
REQ-023 SHALL be a single module with no sub-module; entry array, pointers and retire registers are inline.

Verification
REQ-024 Reset then dispatch tags 0..2 (old_prd 33,34,35, has_dest=1), wb 2,0,1 -> commit_old_preg 33,34,35 on three consecutive cycles, in order.
REQ-025 Dispatch 16 entries -> rob_full=1; 17th dispatch ignored, tail stays 0; wb tag 0 -> retire_rob_tag=0, rob_full drops.
REQ-026 Dispatch tags 0..5, branch at 2; wb tag 2 with mispredict -> branch_mispredict one cycle, tail=3, count=3, later wb tag 4 ignored.
REQ-027 Dispatch has_dest=0 entry, wb it -> retire_valid=1, commit_en=0, commit_old_preg=0.
REQ-028 Run head/tail past index 15 twice with random wb order -> commits strictly in tag order across wrap, rob_tag_err=0.
REQ-029 Dispatch with wrong tag (tail=3, tag=5) -> rob_tag_err=1 stays set; drop reset mid-stream -> all outputs 0, rob_empty=1.
